// File: rtl/vram_writer_pkg.sv
// Shared constants and types for the Game-of-Life video RAM.
//   GRID_COLS/GRID_ROWS : cell grid (20x15, one byte per 32x32-pixel cell)
//   CELL_SHIFT          : log2 of the cell edge in pixels
//   DEPTH/ADDR_W/DATA_W : RAM geometry shared by both ports
//   state_e             : write-side FSM encoding
package vram_writer_pkg;

   localparam int unsigned GRID_COLS  = 20;
   localparam int unsigned GRID_ROWS  = 15;
   localparam int unsigned CELL_SHIFT = 5;
   localparam int unsigned DEPTH      = GRID_COLS * GRID_ROWS;
   localparam int unsigned ADDR_W     = 18;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned PTR_W      = $clog2(DEPTH);

   localparam logic [DATA_W-1:0] CLEAR_VAL = '0;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StClear = 1'b1
   } state_e;

   // Full-width compare so that set upper address bits never alias into the grid.
   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return addr < ADDR_W'(DEPTH);
   endfunction

endpackage

// File: rtl/vram_writer_if.sv
// CPU load/store bus into the video RAM (valid/ready request, registered read return).
//   cpu_valid/cpu_ready : request handshake, transfer when both high
//   cpu_we              : 1 = write, 0 = read
//   cpu_addr/cpu_wdata  : cell index and write data
//   cpu_rdata/cpu_rvalid: read data, valid for the single cycle cpu_rvalid is high
interface vram_writer_if;
   import vram_writer_pkg::*;

   logic              cpu_valid;
   logic              cpu_ready;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   modport master (
      output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata, cpu_rvalid
   );

   modport slave (
      input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata, cpu_rvalid
   );

endinterface

// File: rtl/vram_writer_dp.sv
// Simple dual-port cell RAM.
//   Port A : synchronous write, registered read with a one-cycle rvalid pulse
//   Port B : registered read-only (VGA scan-out)
// Reads whose ok_* flag is low return 0 instead of touching the array.
// Reads sample the array before the same-edge write lands (read-before-write).
module vram_dp #(
   parameter int unsigned Depth = 300,
   parameter int unsigned DataW = 8,
   parameter int unsigned PtrW  = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_a,
   input  logic             re_a,
   input  logic             ok_a,
   input  logic [PtrW-1:0]  addr_a,
   input  logic [DataW-1:0] wdata_a,
   output logic [DataW-1:0] rdata_a,
   output logic             rvalid_a,
   input  logic             ok_b,
   input  logic [PtrW-1:0]  addr_b,
   output logic [DataW-1:0] rdata_b
);

   logic [DataW-1:0] mem [Depth];
   logic [DataW-1:0] rdata_a_q;
   logic             rvalid_a_q;
   logic [DataW-1:0] rdata_b_q;

   // Array itself is never reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= wdata_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_q  <= '0;
         rvalid_a_q <= 1'b0;
      end else begin
         rvalid_a_q <= re_a;
         if (re_a) begin
            rdata_a_q <= ok_a ? mem[addr_a] : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_b_q <= '0;
      end else begin
         rdata_b_q <= ok_b ? mem[addr_b] : '0;
      end
   end

   assign rdata_a  = rdata_a_q;
   assign rvalid_a = rvalid_a_q;
   assign rdata_b  = rdata_b_q;

endmodule

// File: rtl/vram_writer.sv
// Video RAM for the Game-of-Life display with its write side.
//   clk, rst_n : system clock, asynchronous active-low reset
//   cpu        : CPU load/store bus (slave side of vram_writer_if)
//   clear_req  : one-cycle pulse, starts a full-grid clear
//   busy       : clear in progress (CPU stalled)
//   vaddr      : VGA read address (col + row*20)
//   vdata      : VGA read data, one cycle after vaddr, never stalled
module vram_writer
   import vram_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   vram_writer_if.slave      cpu,
   input  logic              clear_req,
   output logic              busy,
   input  logic [ADDR_W-1:0] vaddr,
   output logic [DATA_W-1:0] vdata
);

   state_e           state_q, state_d;
   logic [PTR_W-1:0] clr_ptr_q, clr_ptr_d;

   logic              ready;
   logic              accept;
   logic              cpu_ok;
   logic              vga_ok;
   logic              we_a;
   logic              re_a;
   logic [PTR_W-1:0]  addr_a;
   logic [DATA_W-1:0] wdata_a;

   // A clear request in the same cycle as a CPU request takes priority.
   assign ready  = (state_q == StIdle) && !clear_req;
   assign accept = cpu.cpu_valid && ready;
   assign cpu_ok = in_range(cpu.cpu_addr);
   assign vga_ok = in_range(vaddr);

   assign cpu.cpu_ready = ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (clear_req) begin
               state_d   = StClear;
               clr_ptr_d = '0;
            end
         end
         StClear: begin
            if (clr_ptr_q == PTR_W'(DEPTH - 1)) begin
               state_d   = StIdle;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            clr_ptr_d = '0;
         end
      endcase
   end

   // Port-A mux: the clear engine owns the port for the whole clear.
   always_comb begin
      busy    = 1'b0;
      we_a    = 1'b0;
      re_a    = 1'b0;
      addr_a  = cpu.cpu_addr[PTR_W-1:0];
      wdata_a = cpu.cpu_wdata;
      unique case (state_q)
         StClear: begin
            busy    = 1'b1;
            we_a    = 1'b1;
            addr_a  = clr_ptr_q;
            wdata_a = CLEAR_VAL;
         end
         StIdle: begin
            we_a = accept && cpu.cpu_we && cpu_ok;
            re_a = accept && !cpu.cpu_we;
         end
         default: ;
      endcase
   end

   vram_dp #(
      .Depth (DEPTH),
      .DataW (DATA_W),
      .PtrW  (PTR_W)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_a     (we_a),
      .re_a     (re_a),
      .ok_a     (cpu_ok),
      .addr_a   (addr_a),
      .wdata_a  (wdata_a),
      .rdata_a  (cpu.cpu_rdata),
      .rvalid_a (cpu.cpu_rvalid),
      .ok_b     (vga_ok),
      .addr_b   (vaddr[PTR_W-1:0]),
      .rdata_b  (vdata)
   );

endmodule
